scaled_video_timing: RTL and testbench

Parametrised successor to the fixed 640x480 Counters block. It generates configurable raster timing with selectable sync polarity and a pixel-scaled framebuffer address. It also owns the vblank-synchronised buffer swap, the vblank NMI and a frame counter. It sits between the pixel clock domain and the double-buffered SRAM, replacing the hardwired JK flip-flop decode.

---
 rtl/scaled_video_timing.sv | 164 ++++++++++++++++
 tb/tb_scaled_video_timing.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_video_timing.sv
// Parameterised raster timing generator with pixel-scaled framebuffer address,
// vblank-synchronised buffer swap, vblank NMI and frame counter.
module scaled_video_timing #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter bit          HSYNC_ACTIVE = 1'b0,
  parameter bit          VSYNC_ACTIVE = 1'b0,
  parameter int unsigned SCALE_SHIFT  = 2,
  parameter int unsigned COL_W        = 10,
  parameter int unsigned ROW_W        = 10,
  parameter int unsigned ADDR_W       = 15
) (
  input  logic              PxClock,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic              SwapReq,
  input  logic              NmiEnable,
  input  logic              NmiAck,
  output logic [COL_W-1:0]  Col,
  output logic [ROW_W-1:0]  Row,
  output logic              HBlank,
  output logic              VBlank,
  output logic              HSync,
  output logic              VSync,
  output logic [ADDR_W-1:0] PixAddr,
  output logic              PixValid,
  output logic              VBlankStart,
  output logic              BufSel,
  output logic              SwapPending,
  output logic              NMI_n,
  output logic [7:0]        FrameCount
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CX_W    = COL_W + 1;
  localparam int unsigned RX_W    = ROW_W + 1;
  localparam int unsigned CF_W    = COL_W - SCALE_SHIFT;
  localparam int unsigned RF_W    = ADDR_W - CF_W;

  if (H_TOTAL > (32'd1 << COL_W)) begin : g_chk_h
    $error("H_TOTAL does not fit in the Col counter");
  end
  if (V_TOTAL > (32'd1 << ROW_W)) begin : g_chk_v
    $error("V_TOTAL does not fit in the Row counter");
  end
  if ((SCALE_SHIFT >= COL_W) || (ADDR_W <= CF_W)) begin : g_chk_a
    $error("PixAddr field widths are inconsistent");
  end

  localparam logic [COL_W-1:0] H_LAST  = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_LAST  = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_VIS_R = ROW_W'(V_VISIBLE);
  // Range bounds are one bit wider so a sync pulse ending at 2^W still compares correctly.
  localparam logic [CX_W-1:0]  H_VIS_X = CX_W'(H_VISIBLE);
  localparam logic [CX_W-1:0]  HS_BEG  = CX_W'(H_VISIBLE + H_FRONT);
  localparam logic [CX_W-1:0]  HS_END  = CX_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [RX_W-1:0]  V_VIS_X = RX_W'(V_VISIBLE);
  localparam logic [RX_W-1:0]  VS_BEG  = RX_W'(V_VISIBLE + V_FRONT);
  localparam logic [RX_W-1:0]  VS_END  = RX_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CX_W-1:0]   col_x;
  logic [RX_W-1:0]   row_x;
  logic              hblank_q, hblank_d;
  logic              vblank_q, vblank_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [ADDR_W-1:0] pixaddr_q, pixaddr_d;
  logic              pixvalid_q, pixvalid_d;
  logic              vbs_q, vbs_d;
  logic              bufsel_q, bufsel_d;
  logic              pend_q, pend_d;
  logic              flag_q, flag_d;
  logic              nmi_n_q, nmi_n_d;
  logic [7:0]        fc_q, fc_d;

  assign col_x = {1'b0, col_d};
  assign row_x = {1'b0, row_d};

  // Next position and every output decoded from it, so outputs match the presented Col/Row.
  always_comb begin
    col_d      = col_q + COL_W'(1);
    row_d      = row_q;
    if (col_q == H_LAST) begin
      col_d = '0;
      row_d = (row_q == V_LAST) ? '0 : row_q + ROW_W'(1);
    end

    hblank_d   = (col_x >= H_VIS_X);
    vblank_d   = (row_x >= V_VIS_X);
    hsync_d    = ((col_x >= HS_BEG) && (col_x < HS_END)) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    vsync_d    = ((row_x >= VS_BEG) && (row_x < VS_END)) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    pixvalid_d = ~hblank_d & ~vblank_d;
    pixaddr_d  = {RF_W'(row_d >> SCALE_SHIFT), CF_W'(col_d >> SCALE_SHIFT)};

    // A request arriving on the vblank edge itself is folded into that swap.
    vbs_d      = (col_d == '0) && (row_d == V_VIS_R);
    bufsel_d   = bufsel_q ^ (vbs_d & (pend_q | SwapReq));
    pend_d     = vbs_d ? 1'b0 : (pend_q | SwapReq);
    flag_d     = vbs_d | (flag_q & ~NmiAck);
    nmi_n_d    = ~(flag_d & NmiEnable);
    fc_d       = vbs_d ? fc_q + 8'd1 : fc_q;
  end

  // State and output registers; Enable low freezes everything except the vblank strobe.
  always_ff @(posedge PxClock) begin
    if (!Reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
      hsync_q    <= ~HSYNC_ACTIVE;
      vsync_q    <= ~VSYNC_ACTIVE;
      pixaddr_q  <= '0;
      pixvalid_q <= 1'b1;
      vbs_q      <= 1'b0;
      bufsel_q   <= 1'b0;
      pend_q     <= 1'b0;
      flag_q     <= 1'b0;
      nmi_n_q    <= 1'b1;
      fc_q       <= 8'd0;
    end else if (Enable) begin
      col_q      <= col_d;
      row_q      <= row_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      pixaddr_q  <= pixaddr_d;
      pixvalid_q <= pixvalid_d;
      vbs_q      <= vbs_d;
      bufsel_q   <= bufsel_d;
      pend_q     <= pend_d;
      flag_q     <= flag_d;
      nmi_n_q    <= nmi_n_d;
      fc_q       <= fc_d;
    end else begin
      vbs_q      <= 1'b0;
    end
  end

  assign Col         = col_q;
  assign Row         = row_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign PixAddr     = pixaddr_q;
  assign PixValid    = pixvalid_q;
  assign VBlankStart = vbs_q;
  assign BufSel      = bufsel_q;
  assign SwapPending = pend_q;
  assign NMI_n       = nmi_n_q;
  assign FrameCount  = fc_q;

endmodule

// File: tb/tb_scaled_video_timing.sv
// Bench for scaled_video_timing: a small-raster instance checked every cycle
// against a position model, plus a default-parameter instance for line timing.
module tb_scaled_video_timing;

  localparam int S_HT      = 56;
  localparam int S_VT      = 40;
  localparam int S_FRAME   = S_HT * S_VT;
  localparam int S_VBS_POS = 30 * S_HT;
  localparam int D_FRAME   = 800 * 525;

  logic clk = 1'b0;
  logic rst_n, en, swap, nmi_en, ack;

  logic [5:0]  s_col, s_row;
  logic [6:0]  s_addr;
  logic        s_hbl, s_vbl, s_hs, s_vs, s_pv, s_vbs, s_buf, s_pend, s_nmi;
  logic [7:0]  s_fc;
  logic [9:0]  d_col, d_row;
  logic [14:0] d_addr;
  logic        d_hbl, d_vbl, d_hs, d_vs, d_pv, d_vbs, d_buf, d_pend, d_nmi;
  logic [7:0]  d_fc;

  scaled_video_timing #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b0),
    .SCALE_SHIFT(2), .COL_W(6), .ROW_W(6), .ADDR_W(7)
  ) dut (
    .PxClock(clk), .Reset_n(rst_n), .Enable(en), .SwapReq(swap),
    .NmiEnable(nmi_en), .NmiAck(ack),
    .Col(s_col), .Row(s_row), .HBlank(s_hbl), .VBlank(s_vbl),
    .HSync(s_hs), .VSync(s_vs), .PixAddr(s_addr), .PixValid(s_pv),
    .VBlankStart(s_vbs), .BufSel(s_buf), .SwapPending(s_pend),
    .NMI_n(s_nmi), .FrameCount(s_fc)
  );

  scaled_video_timing dut_def (
    .PxClock(clk), .Reset_n(rst_n), .Enable(en), .SwapReq(swap),
    .NmiEnable(nmi_en), .NmiAck(ack),
    .Col(d_col), .Row(d_row), .HBlank(d_hbl), .VBlank(d_vbl),
    .HSync(d_hs), .VSync(d_vs), .PixAddr(d_addr), .PixValid(d_pv),
    .VBlankStart(d_vbs), .BufSel(d_buf), .SwapPending(d_pend),
    .NMI_n(d_nmi), .FrameCount(d_fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col, row, addr, fc, dcol, drow, daddr;
    bit hbl, vbl, hs, vs, pv, vbs, bsel, pend, nmi_n;
    bit dhbl, dvbl, dhs, dvs, dpv, dpend;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int m_p, m_fc, m_dp;
  bit m_bsel, m_pend, m_flag, m_nmi_n, m_vbs, m_dpend;

  // Raster position -> expected timing outputs, by plain arithmetic.
  function automatic void decode(input int p, input int ht, input int hv, input int hf,
                                 input int hsw, input int vt, input int vv, input int vf,
                                 input int vsw, input int sh, input int colw, input int addrw,
                                 input bit hact, input bit vact,
                                 output int col, output int row, output int addr,
                                 output bit hbl, output bit vbl, output bit hsy, output bit vsy);
    int rfw;
    col  = p % ht;
    row  = (p / ht) % vt;
    hbl  = (col >= hv);
    vbl  = (row >= vv);
    hsy  = (col >= hv + hf && col < hv + hf + hsw) ? hact : !hact;
    vsy  = (row >= vv + vf && row < vv + vf + vsw) ? vact : !vact;
    rfw  = addrw - (colw - sh);
    addr = (((row >> sh) % (1 << rfw)) << (colw - sh)) + (col >> sh);
  endfunction

  task automatic tick(input bit r, input bit e, input bit sw, input bit ne, input bit ak);
    exp_t x;
    rst_n = r; en = e; swap = sw; nmi_en = ne; ack = ak;
    if (!r) begin
      m_p = 0; m_bsel = 0; m_pend = 0; m_flag = 0; m_fc = 0; m_nmi_n = 1; m_vbs = 0;
      m_dp = 0; m_dpend = 0;
    end else if (e) begin
      m_p   = (m_p + 1) % S_FRAME;
      m_vbs = (m_p == S_VBS_POS);
      if (m_vbs) begin
        if (m_pend || sw) m_bsel = !m_bsel;
        m_pend = 0; m_flag = 1; m_fc = (m_fc + 1) % 256;
      end else begin
        if (sw) m_pend = 1;
        if (ak) m_flag = 0;
      end
      m_nmi_n = !(m_flag && ne);
      m_dp    = (m_dp + 1) % D_FRAME;
      if (sw) m_dpend = 1;
    end else begin
      m_vbs = 0;
    end
    decode(m_p, S_HT, 40, 4, 6, S_VT, 30, 3, 2, 2, 6, 7, 1'b1, 1'b0,
           x.col, x.row, x.addr, x.hbl, x.vbl, x.hs, x.vs);
    decode(m_dp, 800, 640, 16, 96, 525, 480, 10, 2, 2, 10, 15, 1'b0, 1'b0,
           x.dcol, x.drow, x.daddr, x.dhbl, x.dvbl, x.dhs, x.dvs);
    x.pv = !x.hbl && !x.vbl; x.dpv = !x.dhbl && !x.dvbl;
    x.vbs = m_vbs; x.bsel = m_bsel; x.pend = m_pend; x.nmi_n = m_nmi_n; x.fc = m_fc;
    x.dpend = m_dpend;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare every presented cycle with the entry pushed when it was driven.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; if (s_col  !== 6'(e.col))  begin errors++; if (errors <= 40) $display("FAIL sb_col t=%0t got %0d exp %0d", $time, s_col, e.col); end
      checks++; if (s_row  !== 6'(e.row))  begin errors++; if (errors <= 40) $display("FAIL sb_row t=%0t got %0d exp %0d", $time, s_row, e.row); end
      checks++; if (s_hbl  !== e.hbl)      begin errors++; if (errors <= 40) $display("FAIL sb_hblank t=%0t got %b exp %b", $time, s_hbl, e.hbl); end
      checks++; if (s_vbl  !== e.vbl)      begin errors++; if (errors <= 40) $display("FAIL sb_vblank t=%0t got %b exp %b", $time, s_vbl, e.vbl); end
      checks++; if (s_hs   !== e.hs)       begin errors++; if (errors <= 40) $display("FAIL sb_hsync t=%0t got %b exp %b", $time, s_hs, e.hs); end
      checks++; if (s_vs   !== e.vs)       begin errors++; if (errors <= 40) $display("FAIL sb_vsync t=%0t got %b exp %b", $time, s_vs, e.vs); end
      checks++; if (s_addr !== 7'(e.addr)) begin errors++; if (errors <= 40) $display("FAIL sb_pixaddr t=%0t got %0d exp %0d", $time, s_addr, e.addr); end
      checks++; if (s_pv   !== e.pv)       begin errors++; if (errors <= 40) $display("FAIL sb_pixvalid t=%0t got %b exp %b", $time, s_pv, e.pv); end
      checks++; if (s_vbs  !== e.vbs)      begin errors++; if (errors <= 40) $display("FAIL sb_vbstart t=%0t got %b exp %b", $time, s_vbs, e.vbs); end
      checks++; if (s_buf  !== e.bsel)     begin errors++; if (errors <= 40) $display("FAIL sb_bufsel t=%0t got %b exp %b", $time, s_buf, e.bsel); end
      checks++; if (s_pend !== e.pend)     begin errors++; if (errors <= 40) $display("FAIL sb_pending t=%0t got %b exp %b", $time, s_pend, e.pend); end
      checks++; if (s_nmi  !== e.nmi_n)    begin errors++; if (errors <= 40) $display("FAIL sb_nmi_n t=%0t got %b exp %b", $time, s_nmi, e.nmi_n); end
      checks++; if (s_fc   !== 8'(e.fc))   begin errors++; if (errors <= 40) $display("FAIL sb_framecount t=%0t got %0d exp %0d", $time, s_fc, e.fc); end
      checks++; if (d_col  !== 10'(e.dcol)) begin errors++; if (errors <= 40) $display("FAIL sb_def_col t=%0t got %0d exp %0d", $time, d_col, e.dcol); end
      checks++; if (d_row  !== 10'(e.drow)) begin errors++; if (errors <= 40) $display("FAIL sb_def_row t=%0t got %0d exp %0d", $time, d_row, e.drow); end
      checks++; if ({d_hbl, d_vbl, d_hs, d_vs, d_pv} !== {e.dhbl, e.dvbl, e.dhs, e.dvs, e.dpv})
        begin errors++; if (errors <= 40) $display("FAIL sb_def_flags t=%0t got %b%b%b%b%b exp %b%b%b%b%b", $time, d_hbl, d_vbl, d_hs, d_vs, d_pv, e.dhbl, e.dvbl, e.dhs, e.dvs, e.dpv); end
      checks++; if (d_addr !== 15'(e.daddr)) begin errors++; if (errors <= 40) $display("FAIL sb_def_pixaddr t=%0t got %h exp %h", $time, d_addr, 15'(e.daddr)); end
      checks++; if ({d_vbs, d_buf, d_pend, d_nmi, d_fc} !== {1'b0, 1'b0, e.dpend, 1'b1, 8'd0})
        begin errors++; if (errors <= 40) $display("FAIL sb_def_ctrl t=%0t got %b%b%b%b/%0d exp 00%b1/0", $time, d_vbs, d_buf, d_pend, d_nmi, d_fc, e.dpend); end
    end
  end

  task automatic run_to_small(input int col, input int row, input bit ne);
    int n = 0;
    while (!(s_col == 6'(col) && s_row == 6'(row)) && n < 3000) begin
      tick(1, 1, 0, ne, 0);
      n++;
    end
    if (n >= 3000) begin checks++; errors++; $display("FAIL run_to_timeout got col %0d row %0d exp col %0d row %0d", s_col, s_row, col, row); end
  endtask

  task automatic test_reset();
    repeat (3) tick(0, 1, 1, 1, 1);
    checks++; if ({s_col, s_row} !== 12'd0) begin errors++; $display("FAIL reset_pos got %0d,%0d exp 0,0", s_col, s_row); end
    checks++; if ({s_hbl, s_vbl, s_pv} !== 3'b001) begin errors++; $display("FAIL reset_blank got %b%b%b exp 001", s_hbl, s_vbl, s_pv); end
    checks++; if ({s_hs, s_vs} !== 2'b01) begin errors++; $display("FAIL reset_sync got %b%b exp 01", s_hs, s_vs); end
    checks++; if ({s_vbs, s_buf, s_pend, s_nmi} !== 4'b0001) begin errors++; $display("FAIL reset_ctrl got %b%b%b%b exp 0001", s_vbs, s_buf, s_pend, s_nmi); end
    checks++; if ({s_fc, 1'b0, s_addr} !== 16'd0) begin errors++; $display("FAIL reset_fc_addr got %0d/%0d exp 0/0", s_fc, s_addr); end
    checks++; if ({d_hs, d_vs, d_addr} !== {2'b11, 15'd0}) begin errors++; $display("FAIL reset_def got %b%b/%h exp 11/0000", d_hs, d_vs, d_addr); end
  endtask

  task automatic test_line_default();
    int first_hbl = -1, first_hs = -1, last_hs = -1, hs_cnt = 0;
    tick(0, 1, 0, 0, 0);
    for (int i = 1; i <= 800; i++) begin
      tick(1, 1, 0, 0, 0);
      if (d_hbl === 1'b1 && first_hbl < 0) first_hbl = int'(d_col);
      if (d_hs === 1'b0) begin
        if (first_hs < 0) first_hs = int'(d_col);
        last_hs = int'(d_col);
        hs_cnt++;
      end
      if (i == 799) begin
        checks++; if ({d_col, d_row} !== {10'd799, 10'd0}) begin errors++; $display("FAIL line_end got %0d,%0d exp 799,0", d_col, d_row); end
      end
    end
    checks++; if (first_hbl != 640) begin errors++; $display("FAIL hblank_rise got %0d exp 640", first_hbl); end
    checks++; if (first_hs != 656 || last_hs != 751) begin errors++; $display("FAIL hsync_span got %0d..%0d exp 656..751", first_hs, last_hs); end
    checks++; if (hs_cnt != 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", hs_cnt); end
    checks++; if ({d_col, d_row} !== {10'd0, 10'd1}) begin errors++; $display("FAIL line_wrap got %0d,%0d exp 0,1", d_col, d_row); end
  endtask

  task automatic test_pixaddr();
    int n = 0;
    while (!(d_col == 10'd5 && d_row == 10'd9) && n < 8000) begin tick(1, 1, 0, 0, 0); n++; end
    checks++; if (d_addr !== 15'h0201) begin errors++; $display("FAIL pixaddr_def_5_9 got %h exp 0201", d_addr); end
    run_to_small(5, 9, 0);
    checks++; if (s_addr !== 7'd33) begin errors++; $display("FAIL pixaddr_5_9 got %0d exp 33", s_addr); end
    run_to_small(39, 29, 0);
    checks++; if (s_addr !== 7'd121) begin errors++; $display("FAIL pixaddr_last_vis got %0d exp 121", s_addr); end
    run_to_small(55, 39, 0);
    checks++; if (s_addr !== 7'd29) begin errors++; $display("FAIL pixaddr_trunc got %0d exp 29", s_addr); end
  endtask

  task automatic test_frame();
    int n = 0;
    tick(0, 1, 0, 0, 0);
    while (s_vbs !== 1'b1 && n < 3000) begin tick(1, 1, 0, 0, 0); n++; end
    checks++; if (n != S_VBS_POS) begin errors++; $display("FAIL vbs_latency got %0d exp %0d", n, S_VBS_POS); end
    checks++; if ({s_col, s_row, s_fc} !== {6'd0, 6'd30, 8'd1}) begin errors++; $display("FAIL vbs_pos got %0d,%0d fc %0d exp 0,30 fc 1", s_col, s_row, s_fc); end
    tick(1, 1, 0, 0, 0);
    checks++; if (s_vbs !== 1'b0) begin errors++; $display("FAIL vbs_single got %b exp 0", s_vbs); end
    n = 1;
    while (s_vbs !== 1'b1 && n < 3000) begin tick(1, 1, 0, 0, 0); n++; end
    checks++; if (n != S_FRAME) begin errors++; $display("FAIL vbs_period got %0d exp %0d", n, S_FRAME); end
    checks++; if (s_fc !== 8'd2) begin errors++; $display("FAIL framecount_2 got %0d exp 2", s_fc); end
  endtask

  task automatic test_swap();
    tick(0, 1, 0, 0, 0);
    run_to_small(0, 10, 0);
    tick(1, 1, 1, 0, 0);
    checks++; if ({s_pend, s_buf} !== 2'b10) begin errors++; $display("FAIL swap_req got pend %b buf %b exp 1 0", s_pend, s_buf); end
    run_to_small(3, 12, 0);
    tick(1, 1, 1, 0, 0);
    run_to_small(55, 29, 0);
    checks++; if ({s_pend, s_buf} !== 2'b10) begin errors++; $display("FAIL swap_wait got pend %b buf %b exp 1 0", s_pend, s_buf); end
    tick(1, 1, 0, 0, 0);
    checks++; if ({s_vbs, s_buf, s_pend} !== 3'b110) begin errors++; $display("FAIL swap_at_vbs got %b%b%b exp 110", s_vbs, s_buf, s_pend); end
    run_to_small(55, 29, 0);
    tick(1, 1, 1, 0, 0);
    checks++; if ({s_vbs, s_buf, s_pend} !== 3'b100) begin errors++; $display("FAIL swap_coincident got %b%b%b exp 100", s_vbs, s_buf, s_pend); end
    run_to_small(55, 29, 0);
    tick(1, 1, 0, 0, 0);
    checks++; if ({s_vbs, s_buf} !== 2'b10) begin errors++; $display("FAIL swap_none got %b%b exp 10", s_vbs, s_buf); end
  endtask

  task automatic test_nmi();
    tick(0, 1, 0, 1, 0);
    run_to_small(55, 29, 1);
    checks++; if (s_nmi !== 1'b1) begin errors++; $display("FAIL nmi_before got %b exp 1", s_nmi); end
    tick(1, 1, 0, 1, 0);
    checks++; if (s_nmi !== 1'b0) begin errors++; $display("FAIL nmi_at_vbs got %b exp 0", s_nmi); end
    run_to_small(0, 35, 1);
    tick(1, 1, 0, 1, 1);
    checks++; if (s_nmi !== 1'b1) begin errors++; $display("FAIL nmi_ack got %b exp 1", s_nmi); end
    run_to_small(55, 29, 1);
    tick(1, 1, 0, 1, 1);
    checks++; if ({s_vbs, s_nmi} !== 2'b10) begin errors++; $display("FAIL nmi_set_wins got %b%b exp 10", s_vbs, s_nmi); end
    tick(1, 1, 0, 0, 0);
    checks++; if (s_nmi !== 1'b1) begin errors++; $display("FAIL nmi_masked got %b exp 1", s_nmi); end
    run_to_small(55, 29, 0);
    tick(1, 1, 0, 0, 0);
    checks++; if ({s_vbs, s_nmi} !== 2'b11) begin errors++; $display("FAIL nmi_masked_vbs got %b%b exp 11", s_vbs, s_nmi); end
    tick(1, 1, 0, 1, 0);
    checks++; if (s_nmi !== 1'b0) begin errors++; $display("FAIL nmi_late_enable got %b exp 0", s_nmi); end
  endtask

  task automatic test_enable();
    tick(0, 1, 0, 1, 0);
    run_to_small(10, 20, 1);
    for (int i = 0; i < 50; i++) begin
      tick(1, 0, i[0], 1, !i[0]);
      checks++; if ({s_col, s_row, s_vbs, s_pend} !== {6'd10, 6'd20, 1'b0, 1'b0}) begin errors++; $display("FAIL freeze got %0d,%0d vbs %b pend %b exp 10,20 vbs 0 pend 0", s_col, s_row, s_vbs, s_pend); end
    end
    tick(1, 1, 0, 1, 0);
    checks++; if (s_col !== 6'd11) begin errors++; $display("FAIL resume got %0d exp 11", s_col); end
    run_to_small(55, 29, 1);
    tick(1, 1, 0, 1, 0);
    tick(1, 0, 0, 1, 0);
    checks++; if ({s_vbs, s_col, s_row, s_fc, s_nmi} !== {1'b0, 6'd0, 6'd30, 8'd1, 1'b0}) begin errors++; $display("FAIL freeze_vbs got vbs %b %0d,%0d fc %0d nmi %b exp 0 0,30 1 0", s_vbs, s_col, s_row, s_fc, s_nmi); end
  endtask

  task automatic test_reset_midframe();
    tick(1, 1, 0, 1, 0);
    run_to_small(0, 35, 1);
    tick(1, 1, 1, 1, 0);
    checks++; if ({s_pend, s_nmi} !== 2'b10) begin errors++; $display("FAIL pre_reset got pend %b nmi %b exp 1 0", s_pend, s_nmi); end
    tick(0, 1, 1, 1, 1);
    checks++; if ({s_col, s_row, s_addr} !== 19'd0) begin errors++; $display("FAIL midreset_pos got %0d,%0d addr %0d exp 0,0,0", s_col, s_row, s_addr); end
    checks++; if ({s_hbl, s_vbl, s_pv, s_hs, s_vs} !== 5'b00101) begin errors++; $display("FAIL midreset_timing got %b%b%b%b%b exp 00101", s_hbl, s_vbl, s_pv, s_hs, s_vs); end
    checks++; if ({s_vbs, s_buf, s_pend, s_nmi, s_fc} !== {4'b0001, 8'd0}) begin errors++; $display("FAIL midreset_ctrl got %b%b%b%b fc %0d exp 0001 fc 0", s_vbs, s_buf, s_pend, s_nmi, s_fc); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; swap = 1'b0; nmi_en = 1'b0; ack = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_line_default();
    test_pixaddr();
    test_frame();
    test_swap();
    test_nmi();
    test_enable();
    test_reset_midframe();
    tick(1, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
